colour_sequencer: RTL and testbench



---
 rtl/colour_sequencer_pkg.sv | 15 +
 rtl/colour_sequencer_button.sv | 58 +++++
 rtl/colour_sequencer.sv | 92 +++++++++
 tb/tb_colour_sequencer.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/colour_sequencer_pkg.sv
// colour_sequencer_pkg: shared colour codes, FSM states and colour advance helper
package colour_sequencer_pkg;

  localparam logic [2:0] COL_OFF   = 3'b000;
  localparam logic [2:0] COL_FIRST = 3'b001;
  localparam logic [2:0] COL_LAST  = 3'b110;

  typedef enum logic {OFF, RUN} state_t;

  // Next legal colour in the 001..110 cycle; illegal codes recover to the first colour
  function automatic logic [2:0] next_colour(input logic [2:0] c);
    return (c == COL_OFF || c == 3'b111 || c == COL_LAST) ? COL_FIRST : c + 3'd1;
  endfunction

endpackage

// File: rtl/colour_sequencer_button.sv
// button_debounce: synchronises and debounces a raw button, emits press and long-press pulses
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 100000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button,
  output logic press,
  output logic long_press
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] H_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] H_MAX  = HW'(HOLD_CYCLES);

  logic [1:0]    sync;
  logic [DW-1:0] db_cnt;
  logic          db;
  logic          db_q;
  logic [HW-1:0] hold_cnt;

  // Two-flop synchroniser for the asynchronous button
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync <= '0;
    else        sync <= {sync[0], button};

  // Debounced level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      db_cnt <= '0;
      db     <= 1'b0;
    end else if (sync[1] == db) begin
      db_cnt <= '0;
    end else if (db_cnt == D_LAST) begin
      db_cnt <= '0;
      db     <= sync[1];
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end

  // Previous debounced level for rising-edge detection
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) db_q <= 1'b0;
    else        db_q <= db;

  // Counts cycles of debounced-high, saturating so the long press fires once per hold
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                 hold_cnt <= '0;
    else if (!db)               hold_cnt <= '0;
    else if (hold_cnt != H_MAX) hold_cnt <= hold_cnt + 1'b1;

  assign press      = db & ~db_q;
  assign long_press = db & (hold_cnt == H_LAST);

endmodule

// File: rtl/colour_sequencer.sv
// colour_sequencer: steps the converter colour code manually or on a timer, long press turns off
module colour_sequencer
  import colour_sequencer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int STEP_CYCLES     = 50000000,
  parameter int HOLD_CYCLES     = 100000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       button,
  input  logic       mode_auto,
  output logic [2:0] colour,
  output logic       enable,
  output logic       step_pulse
);

  localparam int PW = $clog2(STEP_CYCLES);
  localparam logic [PW-1:0] P_LAST = PW'(STEP_CYCLES - 1);

  state_t        state, state_n;
  logic [2:0]    colour_n;
  logic          enable_n;
  logic          step_n;
  logic [PW-1:0] presc, presc_n;
  logic          mode_q;
  logic          press, long_press;
  logic          tc, adv;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .HOLD_CYCLES    (HOLD_CYCLES)
  ) u_button (
    .clk       (clk),
    .rst_n     (rst_n),
    .button    (button),
    .press     (press),
    .long_press(long_press)
  );

  assign tc  = (state == RUN) && mode_auto && mode_q && (presc == P_LAST);
  assign adv = press || tc;

  // State, outputs, prescaler and last mode sample
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= OFF;
      colour     <= COL_OFF;
      enable     <= 1'b0;
      step_pulse <= 1'b0;
      presc      <= '0;
      mode_q     <= 1'b0;
    end else begin
      state      <= state_n;
      colour     <= colour_n;
      enable     <= enable_n;
      step_pulse <= step_n;
      presc      <= presc_n;
      mode_q     <= mode_auto;
    end

  // Next state: long press beats any advance; press and terminal count merge into one advance
  always_comb begin
    state_n  = state;
    colour_n = colour;
    enable_n = enable;
    step_n   = 1'b0;
    presc_n  = '0;
    if (state == OFF) begin
      colour_n = COL_OFF;
      enable_n = 1'b0;
      if (press) begin
        state_n  = RUN;
        colour_n = COL_FIRST;
        enable_n = 1'b1;
        step_n   = 1'b1;
      end
    end else if (long_press) begin
      state_n  = OFF;
      colour_n = COL_OFF;
      enable_n = 1'b0;
    end else begin
      presc_n = (mode_auto && mode_q && !adv) ? presc + 1'b1 : '0;
      if (adv) begin
        colour_n = next_colour(colour);
        enable_n = 1'b1;
        step_n   = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_colour_sequencer.sv
// tb_colour_sequencer: directed self-checking bench for colour_sequencer
module tb_colour_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       button = 1'b0;
  logic       mode_auto = 1'b0;
  logic [2:0] colour;
  logic       enable;
  logic       step_pulse;
  int         n_checks = 0;
  int         n_fail = 0;

  colour_sequencer #(
    .DEBOUNCE_CYCLES(4),
    .STEP_CYCLES    (8),
    .HOLD_CYCLES    (20)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .button    (button),
    .mode_auto (mode_auto),
    .colour    (colour),
    .enable    (enable),
    .step_pulse(step_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Clean press: 10 cycles high then 10 cycles low; colour moves 7 edges after button rises
  task automatic do_press();
    button = 1'b1;
    ticks(10);
    button = 1'b0;
    ticks(10);
  endtask

  initial begin
    logic [2:0] seq [7];
    seq = '{3'b011, 3'b100, 3'b101, 3'b110, 3'b001, 3'b010, 3'b011};
    ticks(2);
    check("reset_colour", 32'(colour), 32'h0);
    check("reset_enable", 32'(enable), 32'h0);
    check("reset_step", 32'(step_pulse), 32'h0);
    rst_n = 1'b1;
    ticks(2);
    do_press();
    do_press();
    do_press();
    check("pre_reset_colour", 32'(colour), 32'h3);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_colour", 32'(colour), 32'h0);
    check("async_reset_enable", 32'(enable), 32'h0);
    ticks(1);
    rst_n = 1'b1;
    ticks(2);
    button = 1'b1;
    ticks(6);
    check("first_press_wait", 32'(colour), 32'h0);
    ticks(1);
    check("first_press_colour", 32'(colour), 32'h1);
    check("first_press_enable", 32'(enable), 32'h1);
    check("first_press_step", 32'(step_pulse), 32'h1);
    ticks(1);
    check("first_press_step_low", 32'(step_pulse), 32'h0);
    ticks(2);
    button = 1'b0;
    ticks(10);
    check("after_release", 32'(colour), 32'h1);
    for (int g = 1; g <= 3; g++) begin
      button = 1'b1;
      ticks(g);
      button = 1'b0;
      ticks(8);
      check($sformatf("glitch_%0d", g), 32'(colour), 32'h1);
    end
    do_press();
    check("clean_press", 32'(colour), 32'h2);
    for (int i = 0; i < 7; i++) begin
      do_press();
      check($sformatf("manual_seq_%0d", i), 32'(colour), 32'(seq[i]));
    end
    mode_auto = 1'b1;
    ticks(8);
    check("auto_wait", 32'(colour), 32'h3);
    ticks(1);
    check("auto_adv1", 32'(colour), 32'h4);
    check("auto_adv1_step", 32'(step_pulse), 32'h1);
    ticks(7);
    check("auto_wait2", 32'(colour), 32'h4);
    ticks(1);
    check("auto_adv2", 32'(colour), 32'h5);
    ticks(1);
    button = 1'b1;
    ticks(6);
    check("tc_press_wait", 32'(colour), 32'h5);
    ticks(1);
    check("tc_press_adv", 32'(colour), 32'h6);
    ticks(1);
    check("tc_press_single", 32'(colour), 32'h6);
    check("tc_press_step_low", 32'(step_pulse), 32'h0);
    ticks(2);
    button = 1'b0;
    ticks(4);
    check("tc_next_wait", 32'(colour), 32'h6);
    ticks(1);
    check("tc_next_adv", 32'(colour), 32'h1);
    ticks(5);
    mode_auto = 1'b0;
    ticks(1);
    mode_auto = 1'b1;
    ticks(2);
    check("mode_restart_early", 32'(colour), 32'h1);
    ticks(6);
    check("mode_restart_wait", 32'(colour), 32'h1);
    ticks(1);
    check("mode_restart_adv", 32'(colour), 32'h2);
    check("mode_restart_step", 32'(step_pulse), 32'h1);
    mode_auto = 1'b0;
    ticks(1);
    do_press();
    do_press();
    check("long_start", 32'(colour), 32'h4);
    button = 1'b1;
    ticks(7);
    check("long_first_adv", 32'(colour), 32'h5);
    ticks(18);
    check("long_before", 32'(colour), 32'h5);
    check("long_before_en", 32'(enable), 32'h1);
    ticks(1);
    check("long_off_colour", 32'(colour), 32'h0);
    check("long_off_enable", 32'(enable), 32'h0);
    check("long_off_step", 32'(step_pulse), 32'h0);
    ticks(4);
    check("long_held", 32'(colour), 32'h0);
    button = 1'b0;
    ticks(10);
    check("long_released", 32'(colour), 32'h0);
    do_press();
    check("repress_colour", 32'(colour), 32'h1);
    check("repress_enable", 32'(enable), 32'h1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
